mailbox_manager: RTL
====================

# mailbox_manager

Parametrised successor to the single-register memory poller. It polls a host-owned flag word in shared SDRAM and, when the host posts work, bursts a configurable-length work block into the mining core as a word stream, then acknowledges. It also accepts solution nonces from the core, writes them back and raises a hardware flag. It sits between the RAM master controller (single-beat read/write handshake) and the hashing core.

## Interface
Parameters:
- ADDR_W, 28, memory address width
- DATA_W, 32, memory data width
- FLAG_ADDR, 28'h8000000, host→FPGA flag word
- HW_FLAG_ADDR, 28'h8000004, FPGA→host flag word
- BLOCK_ADDR, 28'h8000008, first word of the work block
- NONCE_ADDR, 28'h8000068, nonce result word
- BLOCK_WORDS, 24, words per work block (1..256)
- READY_CODE, 32'hAAAA0000, host "new work" value
- ACK_CODE, 32'h0000AAAA, FPGA "block consumed" value
- SOL_CODE, 32'h5555AAAA, FPGA "solution posted" value
- POLL_GAP, 16, idle cycles between polls (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- mem_req  out  1  transaction request, held until completion
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  byte address; valid while mem_req
- mem_wdata  out  DATA_W  write data; valid while mem_req && mem_we
- mem_rdata  in  DATA_W  read data, sampled when mem_rvalid
- mem_rvalid  in  1  read completion pulse
- mem_wdone  in  1  write completion pulse
- blk_valid  out  1  one-cycle strobe: blk_data/blk_index valid
- blk_data  out  DATA_W  work-block word
- blk_index  out  8  word index 0..BLOCK_WORDS-1
- blk_done  out  1  one-cycle pulse after the last word
- sol_valid  in  1  core offers a nonce
- sol_nonce  in  DATA_W  nonce value
- sol_ready  out  1  nonce slot empty; transfer on sol_valid && sol_ready
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, POLL, BLK_RD, ACK_WR, NONCE_WR, SOL_WR.
- IDLE: gap counter counts up. A pending nonce takes priority → NONCE_WR immediately, no gap wait. Otherwise, when the counter reaches POLL_GAP-1 → POLL and the counter clears.
- POLL: read FLAG_ADDR. On mem_rvalid: data == READY_CODE → BLK_RD with word index 0; any other value → IDLE.
- BLK_RD: read BLOCK_ADDR + 4·index. On each mem_rvalid, the same edge registers blk_valid=1, blk_data=mem_rdata, blk_index=index. The last word also registers blk_done=1 and moves to ACK_WR; otherwise the index increments.
- ACK_WR: write ACK_CODE to HW_FLAG_ADDR. On mem_wdone → IDLE.
- NONCE_WR: write the held nonce to NONCE_ADDR. On mem_wdone → SOL_WR.
- SOL_WR: write SOL_CODE to HW_FLAG_ADDR. On mem_wdone, clear the pending flag and → IDLE.
- Nonce slot: one entry. sol_ready = !pending. An accepted nonce is held unchanged until SOL_WR completes. A nonce accepted during POLL/BLK_RD/ACK_WR waits; it is serviced at the next IDLE.
- mem_req is high in POLL, BLK_RD, ACK_WR, NONCE_WR and SOL_WR. It drops for exactly one cycle between consecutive block-word reads, so every beat is a fresh request. mem_addr, mem_we and mem_wdata are registered and stable while mem_req is high.
- Completion strobes that arrive when no matching request is outstanding (mem_rvalid during a write, mem_wdone during a read, either in IDLE) are ignored.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, blk_valid=0, blk_data=0, blk_index=0, blk_done=0, sol_ready=1, busy=0. State IDLE, gap counter 0, pending=0.
- Reset asserted mid-transaction: mem_req drops asynchronously, and any partial block is abandoned without blk_done. After reset releases, the first poll issues POLL_GAP cycles later.
- mem_req rises on the cycle after a state entry. A completion seen on edge N leaves mem_req low on cycle N+1.
- blk_valid and blk_done are exactly one cycle wide. blk_done coincides with blk_valid for index BLOCK_WORDS-1.
- Address arithmetic is modulo 2^ADDR_W, with no wrap detection. The index counter is 8 bits wide, and BLOCK_WORDS=256 is legal.
- sol_ready falls on the edge after acceptance and rises on the edge after the SOL_WR mem_wdone.

## Test plan
- Idle poll: the memory model returns 32'h0 on reads → a read of 28'h8000000 every POLL_GAP+2 cycles (with a 1-cycle responder), no writes, blk_valid never high.
- Work block: the flag returns 32'hAAAA0000 and word k returns 32'h1000+k → 24 blk_valid strobes with index 0..23 and matching data, addresses 28'h8000008..28'h8000064 in steps of 4, blk_done with index 23, then a write of 32'h0000AAAA to 28'h8000004.
- Solution: sol_nonce=32'hDEADBEEF offered in IDLE → sol_ready drops; writes of 32'hDEADBEEF to 28'h8000068 then 32'h5555AAAA to 28'h8000004; sol_ready returns to 1; no poll occurs in between.
- Solution during block: nonce offered at block word 5 → all 24 words are delivered, the ACK write follows, then the nonce and SOL writes. A second sol_valid while pending is not accepted.
- Reset mid-block: reset asserted at word 10 → mem_req drops immediately, all outputs return to their reset values, no blk_done; normal polling resumes afterwards.
- Stray strobes: inject mem_wdone during POLL and mem_rvalid in IDLE → no state change, no blk_valid.

Source files
------------

// File: rtl/mailbox_manager_if.sv
// Bundles the two handshakes of the mailbox manager.
// The memory side is a single-beat read/write request with completion pulses.
// The core side carries the work-block word stream and the nonce hand-off.
interface mailbox_manager_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32
);
  // RAM master controller handshake
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              mem_wdone;
  // Work-block stream towards the hashing core
  logic              blk_valid;
  logic [DATA_W-1:0] blk_data;
  logic [7:0]        blk_index;
  logic              blk_done;
  // Solution nonce from the hashing core
  logic              sol_valid;
  logic [DATA_W-1:0] sol_nonce;
  logic              sol_ready;

  // Mailbox manager side
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid, mem_wdone,
    output blk_valid, blk_data, blk_index, blk_done,
    input  sol_valid, sol_nonce,
    output sol_ready
  );

  // Memory controller / hashing core side
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid, mem_wdone,
    input  blk_valid, blk_data, blk_index, blk_done,
    output sol_valid, sol_nonce,
    input  sol_ready
  );
endinterface

// File: rtl/mailbox_manager.sv
// Mailbox manager: polls a host flag word in shared SDRAM, streams a work block
// into the hashing core when the host posts work, acknowledges it, and writes
// solution nonces back with a hardware flag.
module mailbox_manager #(
  parameter int                ADDR_W       = 28,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] FLAG_ADDR    = 28'h8000000,
  parameter logic [ADDR_W-1:0] HW_FLAG_ADDR = 28'h8000004,
  parameter logic [ADDR_W-1:0] BLOCK_ADDR   = 28'h8000008,
  parameter logic [ADDR_W-1:0] NONCE_ADDR   = 28'h8000068,
  parameter int                BLOCK_WORDS  = 24,
  parameter logic [DATA_W-1:0] READY_CODE   = 32'hAAAA0000,
  parameter logic [DATA_W-1:0] ACK_CODE     = 32'h0000AAAA,
  parameter logic [DATA_W-1:0] SOL_CODE     = 32'h5555AAAA,
  parameter int                POLL_GAP     = 16
) (
  input  logic                clk,
  input  logic                reset,
  mailbox_manager_if.master   bus,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE, POLL, BLK_RD, ACK_WR, NONCE_WR, SOL_WR
  } state_e;

  localparam logic [7:0]  LAST_IDX = 8'(BLOCK_WORDS - 1);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  state_e            state_q, state_d;
  logic [15:0]       gap_q, gap_d;
  logic [7:0]        idx_q, idx_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] nonce_q, nonce_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              blk_valid_q, blk_valid_d;
  logic [DATA_W-1:0] blk_data_q, blk_data_d;
  logic [7:0]        blk_index_q, blk_index_d;
  logic              blk_done_q, blk_done_d;
  logic              sol_ready_q, sol_ready_d;

  // Completions only count against our own outstanding request of the right kind.
  logic rd_done, wr_done;
  assign rd_done = mem_req_q && !mem_we_q && bus.mem_rvalid;
  assign wr_done = mem_req_q &&  mem_we_q && bus.mem_wdone;

  // Next-state and registered-output computation for the whole mailbox FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    gap_d       = gap_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    nonce_d     = nonce_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    blk_valid_d = 1'b0;
    blk_data_d  = blk_data_q;
    blk_index_d = blk_index_q;
    blk_done_d  = 1'b0;

    // Single nonce slot, accepted in any state while empty.
    if (bus.sol_valid && sol_ready_q) begin
      pending_d = 1'b1;
      nonce_d   = bus.sol_nonce;
    end

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = NONCE_WR;
          gap_d   = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = POLL;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end

      POLL: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = FLAG_ADDR;
        end else if (rd_done) begin
          mem_req_d = 1'b0;
          idx_d     = '0;
          state_d   = (bus.mem_rdata == READY_CODE) ? BLK_RD : IDLE;
        end
      end

      BLK_RD: begin
        // Each word is a fresh request: the idle cycle after a completion re-issues.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = BLOCK_ADDR + (ADDR_W'(idx_q) << 2);
        end else if (rd_done) begin
          mem_req_d   = 1'b0;
          blk_valid_d = 1'b1;
          blk_data_d  = bus.mem_rdata;
          blk_index_d = idx_q;
          if (idx_q == LAST_IDX) begin
            blk_done_d = 1'b1;
            state_d    = ACK_WR;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      ACK_WR: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = HW_FLAG_ADDR;
          mem_wdata_d = ACK_CODE;
        end else if (wr_done) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      NONCE_WR: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = NONCE_ADDR;
          mem_wdata_d = nonce_q;
        end else if (wr_done) begin
          mem_req_d = 1'b0;
          state_d   = SOL_WR;
        end
      end

      SOL_WR: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = HW_FLAG_ADDR;
          mem_wdata_d = SOL_CODE;
        end else if (wr_done) begin
          mem_req_d = 1'b0;
          pending_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    sol_ready_d = !pending_d;
  end

  // State and output registers; reset returns everything to an idle, empty mailbox.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; the reset branch is asynchronous so mem_req drops at once.
    if (!reset) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      nonce_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      blk_valid_q <= 1'b0;
      blk_data_q  <= '0;
      blk_index_q <= '0;
      blk_done_q  <= 1'b0;
      sol_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      nonce_q     <= nonce_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      blk_valid_q <= blk_valid_d;
      blk_data_q  <= blk_data_d;
      blk_index_q <= blk_index_d;
      blk_done_q  <= blk_done_d;
      sol_ready_q <= sol_ready_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_data  = blk_data_q;
  assign bus.blk_index = blk_index_q;
  assign bus.blk_done  = blk_done_q;
  assign bus.sol_ready = sol_ready_q;
  assign busy          = (state_q != IDLE);

endmodule
